// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multi-cycle control unit and the RV32I datapath:
// IR fields and status flow in, register/memory strobes and the ALU code flow out.
interface multicycle_control_unit_if #(
   parameter int ALUOP_W = 4
);
   logic [6:0]         Op;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic               zero;
   logic               mem_ready;
   logic [ALUOP_W-1:0] aluOp;
   logic               RUWr;
   logic               ir_wr;
   logic               pc_wr;
   logic               pc_src;
   logic               alu_src_imm;
   logic               mem_rd;
   logic               mem_wr;
   logic               wb_sel;
   logic               trap;
   logic [1:0]         trap_cause;

   modport master (
      input  Op, funct3, funct7, zero, mem_ready,
      output aluOp, RUWr, ir_wr, pc_wr, pc_src, alu_src_imm,
             mem_rd, mem_wr, wb_sel, trap, trap_cause
   );

   modport slave (
      output Op, funct3, funct7, zero, mem_ready,
      input  aluOp, RUWr, ir_wr, pc_wr, pc_src, alu_src_imm,
             mem_rd, mem_wr, wb_sel, trap, trap_cause
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I datapath, with a
// memory-ready wait timeout and a sticky trap for illegal instructions or timeouts.
module multicycle_control_unit #(
   parameter int ALUOP_W  = 4,
   parameter int EN_OPIMM = 1,
   parameter int WAIT_MAX = 15
) (
   input logic                       clk,
   input logic                       rst_n,
   multicycle_control_unit_if.master bus
);

   localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SLT  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE, C_OPIMM, C_LOAD, C_STORE, C_BRANCH
   } cls_t;

   typedef struct packed {
      logic       legal;
      cls_t       cls;
      logic [3:0] op;
   } dec_t;

   function automatic dec_t decode(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7);
      dec_t d;
      logic is_imm;
      d.legal = 1'b1;
      d.cls   = C_RTYPE;
      d.op    = ALU_ADD;
      is_imm  = (op == OP_IMM);
      case (op)
         OP_R, OP_IMM: begin
            d.cls = is_imm ? C_OPIMM : C_RTYPE;
            if (is_imm && EN_OPIMM == 0) d.legal = 1'b0;
            case (f3)
               3'd0: begin
                  // OP-IMM has no SUBI, so funct7 carries immediate bits there
                  if (is_imm || f7 == 7'd0) d.op = ALU_ADD;
                  else if (f7 == 7'd32)     d.op = ALU_SUB;
                  else                      d.legal = 1'b0;
               end
               3'd1: begin
                  d.op = ALU_SLL;
                  if (f7 != 7'd0) d.legal = 1'b0;
               end
               3'd5: begin
                  if (f7 == 7'd0)       d.op = ALU_SRL;
                  else if (f7 == 7'd32) d.op = ALU_SRA;
                  else                  d.legal = 1'b0;
               end
               default: begin
                  case (f3)
                     3'd2:    d.op = ALU_SLT;
                     3'd3:    d.op = ALU_SLTU;
                     3'd4:    d.op = ALU_XOR;
                     3'd6:    d.op = ALU_OR;
                     default: d.op = ALU_AND;
                  endcase
                  if (!is_imm && f7 != 7'd0) d.legal = 1'b0;
               end
            endcase
         end
         OP_LOAD:  d.cls = C_LOAD;
         OP_STORE: d.cls = C_STORE;
         OP_BRANCH: begin
            d.cls = C_BRANCH;
            d.op  = ALU_SUB;
            if (f3[2:1] != 2'b00) d.legal = 1'b0;
         end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

   state_t     state;
   cls_t       cls_q;
   logic [CNT_W-1:0] cnt;
   logic [3:0] aluop_q;
   logic [1:0] cause_q;
   logic       bne_q, mem_rd_q, mem_wr_q, imm_q, ruwr_q, pcwr_q, wbsel_q, br_q, trap_q;
   dec_t       dec;
   logic       tmo;

   assign dec = decode(bus.Op, bus.funct3, bus.funct7);
   assign tmo = (WAIT_MAX != 0) && (cnt == CNT_W'(WAIT_MAX)) && !bus.mem_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cls_q    <= C_RTYPE;
         cnt      <= '0;
         aluop_q  <= '0;
         cause_q  <= 2'b00;
         bne_q    <= 1'b0;
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         imm_q    <= 1'b0;
         ruwr_q   <= 1'b0;
         pcwr_q   <= 1'b0;
         wbsel_q  <= 1'b0;
         br_q     <= 1'b0;
         trap_q   <= 1'b0;
      end else begin
         // Strobes are one-state pulses; each transition re-asserts what the next state needs
         mem_rd_q <= 1'b0;
         mem_wr_q <= 1'b0;
         imm_q    <= 1'b0;
         ruwr_q   <= 1'b0;
         pcwr_q   <= 1'b0;
         wbsel_q  <= 1'b0;
         br_q     <= 1'b0;
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               cnt      <= '0;
               mem_rd_q <= 1'b1;
            end
            S_FETCH: begin
               if (bus.mem_ready) begin
                  state <= S_DECODE;
               end else if (tmo) begin
                  state   <= S_TRAP;
                  trap_q  <= 1'b1;
                  cause_q <= 2'b10;
               end else begin
                  cnt      <= cnt + 1'b1;
                  mem_rd_q <= 1'b1;
               end
            end
            S_DECODE: begin
               if (!dec.legal) begin
                  state   <= S_TRAP;
                  trap_q  <= 1'b1;
                  cause_q <= 2'b01;
               end else begin
                  state   <= S_EXEC;
                  cls_q   <= dec.cls;
                  aluop_q <= dec.op;
                  bne_q   <= bus.funct3[0];
                  imm_q   <= (dec.cls == C_OPIMM) || (dec.cls == C_LOAD) || (dec.cls == C_STORE);
                  br_q    <= (dec.cls == C_BRANCH);
               end
            end
            S_EXEC: begin
               case (cls_q)
                  C_BRANCH: begin
                     state    <= S_FETCH;
                     cnt      <= '0;
                     mem_rd_q <= 1'b1;
                  end
                  C_LOAD: begin
                     state    <= S_MEM;
                     cnt      <= '0;
                     mem_rd_q <= 1'b1;
                  end
                  C_STORE: begin
                     state    <= S_MEM;
                     cnt      <= '0;
                     mem_wr_q <= 1'b1;
                  end
                  default: begin
                     state  <= S_WB;
                     ruwr_q <= 1'b1;
                     pcwr_q <= 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  if (cls_q == C_LOAD) begin
                     state   <= S_WB;
                     ruwr_q  <= 1'b1;
                     pcwr_q  <= 1'b1;
                     wbsel_q <= 1'b1;
                  end else begin
                     state    <= S_FETCH;
                     cnt      <= '0;
                     mem_rd_q <= 1'b1;
                  end
               end else if (tmo) begin
                  state   <= S_TRAP;
                  trap_q  <= 1'b1;
                  cause_q <= 2'b10;
               end else begin
                  cnt      <= cnt + 1'b1;
                  mem_rd_q <= (cls_q == C_LOAD);
                  mem_wr_q <= (cls_q != C_LOAD);
               end
            end
            S_WB: begin
               state    <= S_FETCH;
               cnt      <= '0;
               mem_rd_q <= 1'b1;
            end
            default: state <= S_TRAP;
         endcase
      end
   end

   // Handshake-qualified strobes must react to mem_ready/zero within the same cycle
   assign bus.ir_wr       = (state == S_FETCH) && bus.mem_ready;
   assign bus.pc_wr       = pcwr_q | br_q | (mem_wr_q & bus.mem_ready);
   assign bus.pc_src      = br_q & (bus.zero ^ bne_q);
   assign bus.aluOp       = ALUOP_W'(aluop_q);
   assign bus.RUWr        = ruwr_q;
   assign bus.alu_src_imm = imm_q;
   assign bus.mem_rd      = mem_rd_q;
   assign bus.mem_wr      = mem_wr_q;
   assign bus.wb_sel      = wbsel_q;
   assign bus.trap        = trap_q;
   assign bus.trap_cause  = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: expected per-instruction results are
// queued as each instruction is issued and compared when the unit completes it.
module tb_multicycle_control_unit;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [3:0] aluop;
      logic       imm;
      logic [3:0] ruwr;
      logic [7:0] ruwr_at;
      logic       wbsel;
      logic [3:0] pcwr;
      logic       pcsrc;
      logic       trap;
      logic [1:0] cause;
      logic [7:0] lat;
      logic [7:0] memrd;
      logic [7:0] memwr;
      logic       both;
      logic       hang;
   } rec_t;

   logic  clk;
   logic  rst_n;
   int    checks = 0;
   int    errors = 0;
   rec_t  sb[$];
   logic [14:0] outs;

   logic [2:0] sw_f3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
   logic [6:0] sw_f7 [10] = '{7'd0, 7'd32, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd32, 7'd0, 7'd0};
   logic [3:0] sw_op [10] = '{4'b0010, 4'b0100, 4'b0011, 4'b0110, 4'b1001,
                              4'b0111, 4'b0101, 4'b1000, 4'b0001, 4'b0000};

   multicycle_control_unit_if #(.ALUOP_W(4)) bus ();

   multicycle_control_unit #(.ALUOP_W(4), .EN_OPIMM(1), .WAIT_MAX(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign outs = {bus.aluOp, bus.RUWr, bus.ir_wr, bus.pc_wr, bus.pc_src, bus.alu_src_imm,
                  bus.mem_rd, bus.mem_wr, bus.wb_sel, bus.trap, bus.trap_cause};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic do_reset(input logic rdy);
      @(negedge clk);
      rst_n         = 1'b0;
      bus.mem_ready = rdy;
      bus.Op        = 7'd0;
      bus.funct3    = 3'd0;
      bus.funct7    = 7'd0;
      bus.zero      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one instruction from its FETCH (ir_wr) to the next FETCH or a trap, recording what it saw
   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input int memwait, output rec_t o);
      int  n;
      bit  done;
      o = '0;
      bus.mem_ready = 1'b1;
      n = 0;
      while (bus.ir_wr !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (bus.ir_wr !== 1'b1) begin
         o.hang = 1'b1;
      end else begin
         bus.Op     = op;
         bus.funct3 = f3;
         bus.funct7 = f7;
         bus.zero   = z;
         done = 1'b0;
         for (int c = 1; c <= 60 && !done; c++) begin
            @(posedge clk);
            #1;
            bus.mem_ready = (c >= 3 && c < 3 + memwait) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c == 2) begin
               o.aluop = bus.aluOp;
               o.imm   = bus.alu_src_imm;
            end
            if (bus.RUWr === 1'b1) begin
               o.ruwr    = o.ruwr + 4'd1;
               o.ruwr_at = 8'(c);
               o.wbsel   = bus.wb_sel;
            end
            if (bus.pc_wr === 1'b1) begin
               o.pcwr  = o.pcwr + 4'd1;
               o.pcsrc = bus.pc_src;
            end
            if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) o.both = 1'b1;
            if (bus.mem_wr === 1'b1) o.memwr = o.memwr + 8'd1;
            if (bus.mem_rd === 1'b1 && bus.ir_wr !== 1'b1) o.memrd = o.memrd + 8'd1;
            if (bus.trap === 1'b1) begin
               o.trap  = 1'b1;
               o.cause = bus.trap_cause;
               done    = 1'b1;
            end else if (bus.ir_wr === 1'b1) begin
               o.lat = 8'(c);
               done  = 1'b1;
            end
         end
         if (!done) o.hang = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (outs !== 15'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (outs !== 15'd0) begin errors++; $display("FAIL idle_outs: got %h want 0", outs); end
      @(negedge clk);
      checks++; if (bus.mem_rd !== 1'b1) begin errors++; $display("FAIL reset_fetch_rd: got %b want 1", bus.mem_rd); end
   endtask

   task automatic test_add();
      rec_t e, o;
      do_reset(1'b1);
      @(negedge clk);
      checks++; if (bus.ir_wr !== 1'b1) begin errors++; $display("FAIL add_irwr_c1: got %b want 1", bus.ir_wr); end
      e = '0; e.aluop = 4'b0010; e.ruwr = 4'd1; e.ruwr_at = 8'd3; e.pcwr = 4'd1; e.lat = 8'd4;
      sb.push_back(e);
      issue(OP_R, 3'd0, 7'd0, 1'b0, 0, o);
      e = sb.pop_front();
      checks++; if (o.aluop !== e.aluop) begin errors++; $display("FAIL add_aluop: got %b want %b", o.aluop, e.aluop); end
      checks++; if (o.ruwr_at !== e.ruwr_at) begin errors++; $display("FAIL add_ruwr_cycle: got %0d want %0d", o.ruwr_at, e.ruwr_at); end
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL add_latency: got %0d want %0d", o.lat, e.lat); end
      checks++; if (o.pcwr !== e.pcwr || o.pcsrc !== 1'b0) begin errors++; $display("FAIL add_pcwr: got %0d/%b want %0d/0", o.pcwr, o.pcsrc, e.pcwr); end
      checks++; if (o.imm !== 1'b0) begin errors++; $display("FAIL add_imm: got %b want 0", o.imm); end
   endtask

   task automatic test_rtype_sweep();
      rec_t e, o;
      do_reset(1'b1);
      for (int i = 0; i < 10; i++) begin
         e = '0; e.aluop = sw_op[i]; e.ruwr = 4'd1; e.lat = 8'd4;
         sb.push_back(e);
      end
      for (int i = 0; i < 10; i++) begin
         issue(OP_R, sw_f3[i], sw_f7[i], 1'b0, 0, o);
         e = sb.pop_front();
         checks++; if (o.aluop !== e.aluop) begin errors++; $display("FAIL rsweep_aluop[%0d]: got %b want %b", i, o.aluop, e.aluop); end
         checks++; if (o.ruwr !== e.ruwr || o.lat !== e.lat) begin errors++; $display("FAIL rsweep_wb[%0d]: got ruwr=%0d lat=%0d want ruwr=%0d lat=%0d", i, o.ruwr, o.lat, e.ruwr, e.lat); end
      end
      e = '0; e.trap = 1'b1; e.cause = 2'b01;
      sb.push_back(e);
      issue(OP_R, 3'd0, 7'b0000001, 1'b0, 0, o);
      e = sb.pop_front();
      checks++; if (o.trap !== e.trap || o.cause !== e.cause) begin errors++; $display("FAIL rsweep_illegal: got trap=%b cause=%b want trap=1 cause=01", o.trap, o.cause); end
      checks++; if (o.ruwr !== 4'd0) begin errors++; $display("FAIL rsweep_illegal_ruwr: got %0d want 0", o.ruwr); end
   endtask

   task automatic test_opimm();
      rec_t e, o;
      do_reset(1'b1);
      e = '0; e.aluop = 4'b0010; e.imm = 1'b1; e.lat = 8'd4; sb.push_back(e);
      e = '0; e.aluop = 4'b1000; e.imm = 1'b1; e.lat = 8'd4; sb.push_back(e);
      issue(OP_IMM, 3'd0, 7'd32, 1'b0, 0, o);
      e = sb.pop_front();
      checks++; if (o.aluop !== e.aluop || o.imm !== e.imm) begin errors++; $display("FAIL addi_f7: got %b/%b want %b/%b", o.aluop, o.imm, e.aluop, e.imm); end
      issue(OP_IMM, 3'd5, 7'd32, 1'b0, 0, o);
      e = sb.pop_front();
      checks++; if (o.aluop !== e.aluop || o.imm !== e.imm || o.lat !== e.lat) begin errors++; $display("FAIL srai: got %b/%b/%0d want %b/%b/%0d", o.aluop, o.imm, o.lat, e.aluop, e.imm, e.lat); end
   endtask

   task automatic test_load_wait();
      rec_t e, o;
      do_reset(1'b1);
      e = '0; e.aluop = 4'b0010; e.imm = 1'b1; e.ruwr = 4'd1; e.wbsel = 1'b1; e.memrd = 8'd4; e.lat = 8'd8;
      sb.push_back(e);
      issue(OP_LOAD, 3'd2, 7'd0, 1'b0, 3, o);
      e = sb.pop_front();
      checks++; if (o.memrd !== e.memrd) begin errors++; $display("FAIL load_memrd_cycles: got %0d want %0d", o.memrd, e.memrd); end
      checks++; if (o.ruwr !== e.ruwr || o.wbsel !== e.wbsel) begin errors++; $display("FAIL load_wb: got ruwr=%0d wbsel=%b want 1/1", o.ruwr, o.wbsel); end
      checks++; if (o.trap !== 1'b0 || o.lat !== e.lat) begin errors++; $display("FAIL load_lat: got trap=%b lat=%0d want 0/%0d", o.trap, o.lat, e.lat); end
      checks++; if (o.aluop !== e.aluop || o.imm !== e.imm) begin errors++; $display("FAIL load_alu: got %b/%b want %b/%b", o.aluop, o.imm, e.aluop, e.imm); end
   endtask

   task automatic test_branch();
      rec_t e, o;
      logic [2:0] bf3 [3] = '{3'd0, 3'd1, 3'd1};
      logic       bz  [3] = '{1'b1, 1'b1, 1'b0};
      logic       bsrc[3] = '{1'b1, 1'b0, 1'b1};
      do_reset(1'b1);
      for (int i = 0; i < 3; i++) begin
         e = '0; e.aluop = 4'b0100; e.pcwr = 4'd1; e.pcsrc = bsrc[i]; e.lat = 8'd3;
         sb.push_back(e);
      end
      for (int i = 0; i < 3; i++) begin
         issue(OP_BRANCH, bf3[i], 7'd0, bz[i], 0, o);
         e = sb.pop_front();
         checks++; if (o.pcwr !== e.pcwr || o.pcsrc !== e.pcsrc) begin errors++; $display("FAIL branch_pc[%0d]: got pcwr=%0d src=%b want %0d/%b", i, o.pcwr, o.pcsrc, e.pcwr, e.pcsrc); end
         checks++; if (o.ruwr !== 4'd0 || o.lat !== e.lat || o.aluop !== e.aluop) begin errors++; $display("FAIL branch_seq[%0d]: got ruwr=%0d lat=%0d alu=%b want 0/%0d/%b", i, o.ruwr, o.lat, o.aluop, e.lat, e.aluop); end
      end
      e = '0; e.trap = 1'b1; e.cause = 2'b01; sb.push_back(e);
      issue(OP_BRANCH, 3'd2, 7'd0, 1'b0, 0, o);
      e = sb.pop_front();
      checks++; if (o.trap !== e.trap || o.cause !== e.cause) begin errors++; $display("FAIL branch_f3_illegal: got %b/%b want 1/01", o.trap, o.cause); end
   endtask

   task automatic test_back_to_back();
      rec_t e, o;
      logic [6:0] op_t [6] = '{OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_R, 7'b1111111};
      logic [2:0] f3_t [6] = '{3'd0, 3'd2, 3'd2, 3'd0, 3'd4, 3'd0};
      logic [7:0] lat_t[6] = '{8'd4, 8'd5, 8'd4, 8'd3, 8'd4, 8'd0};
      logic [7:0] wr_t [6] = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0};
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) begin
         e = '0; e.lat = lat_t[i]; e.memwr = wr_t[i]; e.trap = (i == 5); e.cause = (i == 5) ? 2'b01 : 2'b00;
         sb.push_back(e);
      end
      for (int i = 0; i < 6; i++) begin
         issue(op_t[i], f3_t[i], 7'd0, 1'b0, 0, o);
         e = sb.pop_front();
         checks++; if (o.lat !== e.lat || o.hang !== 1'b0) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, o.lat, e.lat); end
         checks++; if (o.memwr !== e.memwr || o.both !== 1'b0) begin errors++; $display("FAIL b2b_memwr[%0d]: got %0d both=%b want %0d", i, o.memwr, o.both, e.memwr); end
         checks++; if (o.trap !== e.trap || o.cause !== e.cause) begin errors++; $display("FAIL b2b_trap[%0d]: got %b/%b want %b/%b", i, o.trap, o.cause, e.trap, e.cause); end
      end
   endtask

   task automatic test_timeout();
      rec_t e;
      int   n;
      bit   seen;
      do_reset(1'b0);
      e = '0; e.memrd = 8'd16; e.trap = 1'b1; e.cause = 2'b10;
      sb.push_back(e);
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (bus.trap === 1'b1) seen = 1'b1;
         else if (bus.mem_rd === 1'b1) n++;
      end
      e = sb.pop_front();
      checks++; if (n !== int'(e.memrd)) begin errors++; $display("FAIL timeout_cycles: got %0d want %0d", n, e.memrd); end
      checks++; if (bus.trap !== e.trap || bus.trap_cause !== e.cause) begin errors++; $display("FAIL timeout_cause: got %b/%b want 1/10", bus.trap, bus.trap_cause); end
      checks++; if (bus.mem_rd !== 1'b0) begin errors++; $display("FAIL timeout_memrd: got %b want 0", bus.mem_rd); end
      do_reset(1'b0);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.ir_wr !== 1'b1 || bus.trap !== 1'b0) begin errors++; $display("FAIL timeout_race_irwr: got ir_wr=%b trap=%b want 1/0", bus.ir_wr, bus.trap); end
      @(negedge clk);
      checks++; if (bus.trap !== 1'b0 || bus.mem_rd !== 1'b0) begin errors++; $display("FAIL timeout_race_decode: got trap=%b mem_rd=%b want 0/0", bus.trap, bus.mem_rd); end
   endtask

   task automatic test_reset_mid_store();
      int n;
      do_reset(1'b1);
      @(negedge clk);
      bus.Op = OP_STORE;
      bus.funct3 = 3'd2;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      n = 0;
      while (bus.mem_wr !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL store_memwr: got %b want 1", bus.mem_wr); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.mem_wr !== 1'b0 || outs !== 15'd0) begin errors++; $display("FAIL store_async_reset: got mem_wr=%b outs=%h want 0/0", bus.mem_wr, outs); end
      bus.mem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (outs !== 15'd0) begin errors++; $display("FAIL store_idle: got %h want 0", outs); end
      @(negedge clk);
      checks++; if (bus.ir_wr !== 1'b1 || bus.mem_rd !== 1'b1) begin errors++; $display("FAIL store_refetch: got ir_wr=%b mem_rd=%b want 1/1", bus.ir_wr, bus.mem_rd); end
   endtask

   initial begin
      rst_n         = 1'b1;
      bus.Op        = 7'd0;
      bus.funct3    = 3'd0;
      bus.funct7    = 7'd0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;
      #3;
      test_reset();
      test_add();
      test_rtype_sweep();
      test_opimm();
      test_load_wait();
      test_branch();
      test_back_to_back();
      test_timeout();
      test_reset_mid_store();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
